divider_datapath: RTL and testbench

//   Restoring-division datapath driven by the controller block's load/add/shift/inbit/sel/valid

---
 rtl/divider_datapath_pkg.sv | 13 +
 rtl/divider_addsub.sv | 16 +
 rtl/divider_datapath.sv | 121 ++++++++++++
 tb/tb_divider_datapath.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_datapath_pkg.sv
// Shared definitions for the restoring divider (datapath and controller).
//   DIV_WIDTH : default operand width
//   SEL_*     : partial-remainder source select codes driven by the controller
package divider_datapath_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_ALU  = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;
    localparam logic [1:0] SEL_PASS = 2'd3;

endpackage

// File: rtl/divider_addsub.sv
// Combinational add/subtract for the partial-remainder ALU.
//   a, b : operands (WIDTH bits, two's complement)
//   sub  : 1 -> y = a - b, 0 -> y = a + b
//   y    : result, wraps modulo 2^WIDTH
module divider_addsub #(
    parameter int unsigned WIDTH = 10
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/divider_datapath.sv
// Restoring-division datapath: divisor, partial remainder and quotient registers,
// steered cycle by cycle by controller strobes; captures finished results.
//   clk, reset          : clock, synchronous active-low reset
//   dividend, divisor   : operands, sampled on load
//   load/add/shift/inbit/sel/valid : controller strobes
//   sign                : partial remainder sign bit, fed back to the controller
//   quotient, remainder : captured results
//   result_valid        : results held in quotient/remainder
//   div_by_zero         : divisor was zero at the last load
module divider_datapath
    import divider_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             load,
    input  logic             add,
    input  logic             shift,
    input  logic             inbit,
    input  logic [1:0]       sel,
    input  logic             valid,
    output logic             sign,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_valid,
    output logic             div_by_zero
);

    // Two guard bits: the remainder stays below 2*D and the trial result may go negative.
    localparam int unsigned RW = WIDTH + 2;

    logic [WIDTH-1:0] d_q;
    logic [RW-1:0]    r_q;
    logic [WIDTH-1:0] q_q;

    logic [WIDTH-1:0] d_next;
    logic [RW-1:0]    r_base;
    logic [WIDTH-1:0] q_base;
    logic [RW-1:0]    r_next;
    logic [WIDTH-1:0] q_next;

    logic             alu_add;
    logic             alu_sub;
    logic [RW-1:0]    alu_y;
    logic             shift_bit;

    // Qualify don't-care strobes so a floating add/inbit cannot reach state.
    assign alu_add   = !load && (sel == SEL_ALU) && add;
    assign alu_sub   = !alu_add;
    assign shift_bit = shift && inbit;

    divider_addsub #(
        .WIDTH (RW)
    ) u_addsub (
        .a   (r_q),
        .b   ({2'b00, d_q}),
        .sub (alu_sub),
        .y   (alu_y)
    );

    // Operand/remainder source selection, then optional {R,Q} left shift.
    always_comb begin
        d_next = d_q;
        r_base = r_q;
        q_base = q_q;
        r_next = r_q;
        q_next = q_q;

        if (load) begin
            d_next = divisor;
            r_base = '0;
            q_base = dividend;
        end else begin
            case (sel)
                SEL_ALU:  r_base = alu_y;
                SEL_ZERO: r_base = '0;
                default:  r_base = r_q;
            endcase
        end

        if (shift) begin
            r_next = {r_base[RW-2:0], q_base[WIDTH-1]};
            q_next = {q_base[WIDTH-2:0], shift_bit};
        end else begin
            r_next = r_base;
            q_next = q_base;
        end
    end

    // State and result registers; load takes priority over capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            d_q          <= '0;
            r_q          <= '0;
            q_q          <= '0;
            quotient     <= '0;
            remainder    <= '0;
            result_valid <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            d_q <= d_next;
            r_q <= r_next;
            q_q <= q_next;
            if (load) begin
                result_valid <= 1'b0;
                div_by_zero  <= (divisor == '0);
            end else if (valid) begin
                quotient     <= q_q;
                // The last shift doubles R, so the true remainder sits one bit up.
                remainder    <= r_q[WIDTH:1];
                result_valid <= 1'b1;
            end
        end
    end

    assign sign = r_q[RW-1];

endmodule

// File: tb/tb_divider_datapath.sv
// Self-checking bench for divider_datapath: table-driven directed divisions,
// randomized divisions against a plain-arithmetic model, and hand-written
// corner sequences (mid-division reset, load+valid collision, floating strobes).
module tb_divider_datapath;
    import divider_datapath_pkg::*;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         load;
    logic         add;
    logic         shift;
    logic         inbit;
    logic [1:0]   sel;
    logic         valid;
    logic         sign;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         result_valid;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;
    int x_events = 0;
    bit x_watch  = 1'b0;

    divider_datapath #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .dividend     (dividend),
        .divisor      (divisor),
        .load         (load),
        .add          (add),
        .shift        (shift),
        .inbit        (inbit),
        .sel          (sel),
        .valid        (valid),
        .sign         (sign),
        .quotient     (quotient),
        .remainder    (remainder),
        .result_valid (result_valid),
        .div_by_zero  (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floating strobes must never leak into state or outputs.
    always @(negedge clk) begin
        if (x_watch && $isunknown({dut.d_q, dut.r_q, dut.q_q, quotient, remainder,
                                   sign, result_valid, div_by_zero}))
            x_events++;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_dbz;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load  = 1'b0;
        valid = 1'b0;
        sel   = SEL_HOLD;
        add   = 1'b0;
        shift = 1'b0;
        inbit = 1'b0;
    endtask

    // Load with the initial shift folded in; sel/add are don't-care here.
    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b, input logic lv);
        load     = 1'b1;
        valid    = lv;
        dividend = a;
        divisor  = b;
        shift    = 1'b1;
        inbit    = 1'b0;
        sel      = SEL_ALU;
        add      = 1'bz;
        tick();
        idle();
    endtask

    // One iteration as the controller would sequence it, steering on sign.
    task automatic do_iter(output logic s);
        sel   = SEL_ALU;
        add   = 1'b0;
        shift = 1'b0;
        inbit = 1'bz;
        tick();
        s = sign;
        if (s === 1'b1) begin
            sel   = SEL_ALU;
            add   = 1'b1;
            shift = 1'b1;
            inbit = 1'b0;
        end else begin
            sel   = SEL_PASS;
            add   = 1'bz;
            shift = 1'b1;
            inbit = 1'b1;
        end
        tick();
        idle();
    endtask

    task automatic do_capture();
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        logic [W-1:0] svec;
        logic [W-1:0] exp_signs;
        logic         s;
        do_load(a, b, 1'b0);
        for (int i = 0; i < int'(W); i++) begin
            do_iter(s);
            svec[W-1-i] = s;
        end
        do_capture();
        exp_signs = ~eq;
        check({tag, "_quotient"},  32'(quotient),     32'(eq));
        check({tag, "_remainder"}, 32'(remainder),    32'(er));
        check({tag, "_valid"},     32'(result_valid), 32'd1);
        check({tag, "_dbz"},       32'(div_by_zero),  32'(edbz));
        check({tag, "_signs"},     32'(svec),         32'(exp_signs));
    endtask

    initial begin
        logic [W-1:0] ra, rb, mq, mr;
        logic         s;

        vecs[0] = '{a: 8'd200, b: 8'd7,  exp_q: 8'd28,  exp_r: 8'd4,   exp_dbz: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,  exp_q: 8'd255, exp_r: 8'd0,   exp_dbz: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 8'd10, exp_q: 8'd0,   exp_r: 8'd5,   exp_dbz: 1'b0};
        vecs[3] = '{a: 8'd9,   b: 8'd3,  exp_q: 8'd3,   exp_r: 8'd0,   exp_dbz: 1'b0};
        vecs[4] = '{a: 8'd100, b: 8'd0,  exp_q: 8'd255, exp_r: 8'd100, exp_dbz: 1'b1};

        dividend = '0;
        divisor  = '0;
        idle();
        reset = 1'b0;
        tick();
        tick();
        check("rst_quotient",  32'(quotient),     32'd0);
        check("rst_remainder", 32'(remainder),    32'd0);
        check("rst_flags",     32'({result_valid, div_by_zero, sign}), 32'd0);
        reset   = 1'b1;
        x_watch = 1'b1;

        foreach (vecs[k])
            run_div($sformatf("vec%0d", k), vecs[k].a, vecs[k].b,
                    vecs[k].exp_q, vecs[k].exp_r, vecs[k].exp_dbz);

        // Reset in the middle of 200/7 clears everything, even with load/valid high.
        do_load(8'd200, 8'd7, 1'b0);
        for (int i = 0; i < 3; i++) do_iter(s);
        sel   = SEL_ALU;
        add   = 1'b0;
        shift = 1'b0;
        tick();
        reset    = 1'b0;
        load     = 1'b1;
        valid    = 1'b1;
        shift    = 1'b1;
        dividend = 8'hff;
        divisor  = 8'h00;
        tick();
        check("midrst_quotient",  32'(quotient),  32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_flags",     32'({result_valid, div_by_zero, sign}), 32'd0);
        check("midrst_regs",      32'({dut.d_q, dut.q_q, dut.r_q}), 32'd0);
        reset = 1'b1;
        idle();
        run_div("after_rst", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

        // Load colliding with valid: no capture, earlier results stay put.
        run_div("prev", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
        do_load(8'd77, 8'd5, 1'b0);
        for (int i = 0; i < 3; i++) do_iter(s);
        do_load(8'd13, 8'd4, 1'b1);
        check("lv_valid",     32'(result_valid), 32'd0);
        check("lv_quotient",  32'(quotient),     32'd8);
        check("lv_remainder", 32'(remainder),    32'd2);
        for (int i = 0; i < int'(W); i++) do_iter(s);
        check("hold_quotient",  32'(quotient),  32'd8);
        check("hold_remainder", 32'(remainder), 32'd2);
        do_capture();
        check("lv_new_quotient",  32'(quotient),     32'd3);
        check("lv_new_remainder", 32'(remainder),    32'd1);
        check("lv_new_valid",     32'(result_valid), 32'd1);

        // Randomized divisions against integer arithmetic.
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = (n % 6 == 5) ? W'(0) : W'($urandom_range(1, 255));
            if (rb == 0) begin
                mq = '1;
                mr = ra;
            end else begin
                mq = ra / rb;
                mr = ra % rb;
            end
            run_div($sformatf("rnd%0d_%0d_%0d", n, ra, rb), ra, rb, mq, mr, rb == 0);
        end

        check("no_x_on_state", 32'(x_events), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
